// File: rtl/btn_conditioner.sv
// Movement button front end: synchronize, debounce, detect presses, auto-repeat,
// and hand single-step direction requests to the player stage over valid/ready.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_RATE     = 2500000,
  parameter int ACTIVE_LOW      = 1,
  parameter int CNT_W           = 24
) (
  input  logic       CLOCK_25,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       dir_ready,
  output logic       dir_valid,
  output logic [1:0] dir_code,
  output logic [3:0] btn_held
);

  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} state_t;

  logic [3:0]       raw;
  logic [3:0]       norm;
  logic [3:0]       sync1;
  logic [3:0]       sync2;
  logic [3:0]       sync3;
  logic [3:0]       stable;
  logic [3:0]       stable_d;
  logic [3:0]       rise;
  logic [CNT_W-1:0] db_cnt [4];

  state_t           state;
  state_t           state_n;
  logic [1:0]       active;
  logic [1:0]       active_n;
  logic [1:0]       press_dir;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] timer_n;
  logic             evt;

  assign raw  = {btn_right, btn_left, btn_down, btn_up};
  assign norm = (ACTIVE_LOW != 0) ? ~raw : raw;

  // Third stage registers the normalized level so a debounce decision never sees
  // the metastability-prone second flop directly.
  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      sync3    <= '0;
      stable_d <= '0;
    end else begin
      sync1    <= norm;
      sync2    <= sync1;
      sync3    <= sync2;
      stable_d <= stable;
    end
  end

  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) begin
      stable <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync3[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= sync3[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_ONE;
        end
      end
    end
  end

  assign rise     = stable & ~stable_d;
  assign btn_held = stable;

  always_comb begin
    press_dir = 2'd3;
    if (rise[0])      press_dir = 2'd0;
    else if (rise[1]) press_dir = 2'd1;
    else if (rise[2]) press_dir = 2'd2;
  end

  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      active <= 2'd0;
      timer  <= '0;
    end else begin
      state  <= state_n;
      active <= active_n;
      timer  <= timer_n;
    end
  end

  // A new press always takes over; release is checked before a due repeat so a
  // release landing on the repeat edge suppresses it.
  always_comb begin
    state_n  = state;
    active_n = active;
    timer_n  = timer + CNT_ONE;
    evt      = 1'b0;
    case (state)
      S_IDLE: begin
        timer_n = '0;
        if (|rise) begin
          active_n = press_dir;
          evt      = 1'b1;
          state_n  = S_DELAY;
        end
      end
      S_DELAY, S_REPEAT: begin
        if (|rise) begin
          active_n = press_dir;
          evt      = 1'b1;
          state_n  = S_DELAY;
          timer_n  = '0;
        end else if (!stable[active]) begin
          state_n = S_IDLE;
          timer_n = '0;
        end else if (state == S_DELAY && timer == DELAY_LAST) begin
          evt     = 1'b1;
          state_n = S_REPEAT;
          timer_n = '0;
        end else if (state == S_REPEAT && timer == RATE_LAST) begin
          evt     = 1'b1;
          timer_n = '0;
        end
      end
      default: begin
        state_n = S_IDLE;
        timer_n = '0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) begin
      dir_valid <= 1'b0;
      dir_code  <= 2'd0;
    end else if (evt && (!dir_valid || dir_ready)) begin
      dir_valid <= 1'b1;
      dir_code  <= active_n;
    end else if (dir_valid && dir_ready) begin
      dir_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: table of press patterns plus hand-written stall,
// overlapping-press and mid-operation reset sequences, checked by a scoreboard.
module tb_btn_conditioner;

  logic       CLOCK_25 = 1'b0;
  logic       reset;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       dir_ready;
  logic       dir_valid;
  logic [1:0] dir_code;
  logic [3:0] btn_held;

  int cycle  = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int code;
    int cyc;
  } exp_t;

  typedef struct {
    logic [3:0] mask;
    int         hold;
    int         exp_code;
    int         exp_events;
  } vec_t;

  exp_t sb[$];
  vec_t vecs [8];

  btn_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_RATE    (8),
    .ACTIVE_LOW     (1),
    .CNT_W          (24)
  ) dut (
    .CLOCK_25 (CLOCK_25),
    .reset    (reset),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .btn_left (btn_left),
    .btn_right(btn_right),
    .dir_ready(dir_ready),
    .dir_valid(dir_valid),
    .dir_code (dir_code),
    .btn_held (btn_held)
  );

  always #20 CLOCK_25 = ~CLOCK_25;

  always @(posedge CLOCK_25) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cycle);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] mask);
    btn_up    = ~mask[0];
    btn_down  = ~mask[1];
    btn_left  = ~mask[2];
    btn_right = ~mask[3];
  endtask

  task automatic tick();
    @(posedge CLOCK_25);
    #1;
  endtask

  // First request is visible 7 edges after the press reaches the pins, then 20, then every 8.
  task automatic pushEvents(input int code, input int base, input int count);
    int t;
    t = 7;
    for (int k = 0; k < count; k++) begin
      sb.push_back('{code: code, cyc: base + t});
      t += (k == 0) ? 20 : 8;
    end
  endtask

  always @(negedge CLOCK_25) begin
    if (!reset && dir_valid && dir_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_xfer: got code %0d expected no transfer at cycle %0d",
                 dir_code, cycle);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("xfer_code", int'(dir_code), e.code);
        checkOutput("xfer_cycle", cycle, e.cyc);
      end
    end
  end

  initial begin
    int base;
    int hold;
    int exp_held;
    int end_cyc;

    vecs[0] = '{4'b0100, 10, 2, 1};
    vecs[1] = '{4'b0001, 40, 0, 4};
    vecs[2] = '{4'b1000,  3, 0, 0};
    vecs[3] = '{4'b0011, 12, 0, 1};
    vecs[4] = '{4'b0010, 20, 1, 1};
    vecs[5] = '{4'b0010, 21, 1, 2};
    vecs[6] = '{4'b1000,  4, 3, 1};
    vecs[7] = '{4'b1100, 30, 2, 3};

    reset     = 1'b1;
    dir_ready = 1'b1;
    applyStimulus(4'b0000);
    repeat (3) tick();
    checkOutput("reset_valid", int'(dir_valid), 0);
    checkOutput("reset_code", int'(dir_code), 0);
    checkOutput("reset_held", int'(btn_held), 0);
    reset = 1'b0;
    repeat (10) tick();
    checkOutput("idle_valid", int'(dir_valid), 0);
    checkOutput("idle_held", int'(btn_held), 0);

    for (int v = 0; v < 8; v++) begin
      hold = vecs[v].hold;
      applyStimulus(vecs[v].mask);
      base = cycle + 1;
      pushEvents(vecs[v].exp_code, base, vecs[v].exp_events);
      end_cyc = base + hold + 12;
      while (cycle < end_cyc) begin
        tick();
        if (cycle == base - 1 + hold) applyStimulus(4'b0000);
        exp_held = (hold >= 4 && cycle >= base + 6 && cycle <= base + hold + 5)
                   ? int'(vecs[v].mask) : 0;
        checkOutput("vec_held", int'(btn_held), exp_held);
      end
      checkOutput("vec_sb_empty", sb.size(), 0);
    end

    $display("[TB] up+down together, then up released while down held");
    applyStimulus(4'b0011);
    base = cycle + 1;
    pushEvents(0, base, 1);
    while (cycle < base + 60) begin
      tick();
      if (cycle == base + 14) applyStimulus(4'b0010);
      if (cycle == base + 10) checkOutput("pair_held", int'(btn_held), 3);
    end
    checkOutput("pair_down_held", int'(btn_held), 2);
    applyStimulus(4'b0000);
    repeat (15) tick();
    checkOutput("pair_released", int'(btn_held), 0);
    checkOutput("pair_sb_empty", sb.size(), 0);

    $display("[TB] down pressed with dir_ready low");
    dir_ready = 1'b0;
    applyStimulus(4'b0010);
    base = cycle + 1;
    sb.push_back('{code: 1, cyc: base + 40});
    while (cycle < base + 40) begin
      tick();
      if (cycle == base + 29) applyStimulus(4'b0000);
      if (cycle >= base + 7) begin
        checkOutput("stall_valid", int'(dir_valid), 1);
        checkOutput("stall_code", int'(dir_code), 1);
      end
    end
    dir_ready = 1'b1;
    tick();
    checkOutput("stall_after_xfer", int'(dir_valid), 0);
    repeat (15) tick();
    checkOutput("stall_sb_empty", sb.size(), 0);

    $display("[TB] reset while repeating");
    applyStimulus(4'b0001);
    base = cycle + 1;
    pushEvents(0, base, 1);
    while (cycle < base + 27) tick();
    checkOutput("pre_reset_valid", int'(dir_valid), 1);
    reset = 1'b1;
    #1;
    checkOutput("mid_reset_valid", int'(dir_valid), 0);
    checkOutput("mid_reset_held", int'(btn_held), 0);
    repeat (3) tick();
    reset = 1'b0;
    base = cycle + 1;
    pushEvents(0, base, 1);
    while (cycle < base + 19) begin
      tick();
      if (cycle == base + 6) checkOutput("post_reset_held", int'(btn_held), 1);
    end
    applyStimulus(4'b0000);
    while (cycle < base + 40) tick();
    checkOutput("post_reset_released", int'(btn_held), 0);
    checkOutput("final_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
